// File: rtl/fir_mem_pkg.sv
// Shared types and default widths for the FIR sample/result buffer controller.
package fir_mem_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/fir_mem_ctrl_if.sv
// AXI-side access bus of the FIR buffer controller: host writes the input RAM, reads the output RAM.
interface fir_mem_ctrl_if
  import fir_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) ();

  // Strobe semantics, no back-pressure: axi_wr is sampled every rising edge and
  // accepted only while the controller is idle; axi_rd_data returns the word at
  // axi_rd_addr one cycle after the address is presented (zero while busy).
  logic [ADDR_W-1:0] axi_wr_addr;
  logic [DIN_W-1:0]  axi_wr_data;
  logic              axi_wr;
  logic [ADDR_W-1:0] axi_rd_addr;
  logic [DOUT_W-1:0] axi_rd_data;

  modport master (
    output axi_wr_addr, axi_wr_data, axi_wr, axi_rd_addr,
    input  axi_rd_data
  );

  modport slave (
    input  axi_wr_addr, axi_wr_data, axi_wr, axi_rd_addr,
    output axi_rd_data
  );

endinterface

// File: rtl/ram.sv
// Single-port RAM: synchronous write, registered read (read-before-write); only the
// read register is reset so stored contents survive a reset.
module ram
  import fir_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/fir_mem_ctrl.sv
// Streams a block of samples from the input RAM to an external FIR and stores its
// results in the output RAM; single-pass or continuous, abortable at any time.
module fir_mem_ctrl
  import fir_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic                a_clk,
  input  logic                a_rst,
  fir_mem_ctrl_if.slave       axi,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [ADDR_W:0]     sample_count,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                axi_err,
  input  logic                err_clr,
  output logic [DIN_W-1:0]    fir_sample,
  output logic                fir_sample_valid,
  input  logic [DOUT_W-1:0]   fir_result,
  input  logic                fir_result_valid,
  output fsm_state_t          state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  fsm_state_t state_q, state_d;

  logic [CNT_W-1:0]  eff_count;
  logic [CNT_W-1:0]  clamped;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  wr_ptr;
  logic              launch;
  logic              run_abort;
  logic              issue;
  logic              res_we;
  logic              sample_valid_q;
  logic              aborted_q;
  logic              rd_ok_q;
  logic              axi_err_q;

  logic [ADDR_W-1:0] in_addr;
  logic              in_we;
  logic [DIN_W-1:0]  in_rdata;
  logic [ADDR_W-1:0] out_addr;
  logic [DOUT_W-1:0] out_rdata;

  // Requests beyond the RAM depth are clamped so the pointers never wrap.
  assign clamped   = (sample_count > DEPTH) ? DEPTH : sample_count;
  assign launch    = (state_q == ST_IDLE) && start && !abort && (clamped != '0);
  assign run_abort = abort && (state_q != ST_IDLE);
  assign issue     = (state_q == ST_RUN) && !abort && (rd_ptr < eff_count);
  assign res_we    = (state_q == ST_RUN) && !abort && fir_result_valid && (wr_ptr < eff_count);

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                     state_d = ST_IDLE;
        else if (wr_ptr == eff_count)  state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort)     state_d = ST_IDLE;
        else if (mode) state_d = ST_RUN;
        else           state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointers only advance while staying in RUN; any entry into RUN starts them at 0.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (issue)  rd_ptr <= rd_ptr + 1'b1;
      if (res_we) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      eff_count      <= '0;
      sample_valid_q <= 1'b0;
      aborted_q      <= 1'b0;
      rd_ok_q        <= 1'b0;
      axi_err_q      <= 1'b0;
    end else begin
      if (launch) eff_count <= clamped;
      sample_valid_q <= issue;
      aborted_q      <= run_abort;
      rd_ok_q        <= (state_q == ST_IDLE);
      if (axi.axi_wr && busy) axi_err_q <= 1'b1;
      else if (err_clr)       axi_err_q <= 1'b0;
    end
  end

  assign in_addr  = (state_q == ST_RUN) ? rd_ptr[ADDR_W-1:0] : axi.axi_wr_addr;
  assign in_we    = (state_q == ST_IDLE) && axi.axi_wr;
  assign out_addr = (state_q == ST_RUN) ? wr_ptr[ADDR_W-1:0] : axi.axi_rd_addr;

  ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DIN_W)
  ) u_in_ram (
    .clk   (a_clk),
    .rst   (a_rst),
    .we    (in_we),
    .addr  (in_addr),
    .wdata (axi.axi_wr_data),
    .rdata (in_rdata)
  );

  ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DOUT_W)
  ) u_out_ram (
    .clk   (a_clk),
    .rst   (a_rst),
    .we    (res_we),
    .addr  (out_addr),
    .wdata (fir_result),
    .rdata (out_rdata)
  );

  // Read data is only meaningful when its address came from the AXI side.
  assign axi.axi_rd_data  = (rd_ok_q && (state_q == ST_IDLE)) ? out_rdata : '0;
  assign fir_sample       = sample_valid_q ? in_rdata : '0;
  assign fir_sample_valid = sample_valid_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign aborted          = aborted_q;
  assign axi_err          = axi_err_q;
  assign state            = state_q;

endmodule

// File: tb/tb_fir_mem_ctrl.sv
// Directed-plus-random bench for fir_mem_ctrl with an echo FIR (sample+1, 3-cycle latency).
module tb_fir_mem_ctrl;
  import fir_mem_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DIN_W  = 16;
  localparam int DOUT_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic a_clk = 1'b0;
  logic a_rst;
  always #5 a_clk = ~a_clk;

  fir_mem_ctrl_if #(.ADDR_W(ADDR_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) bus ();

  logic              start, abort, mode, err_clr;
  logic [ADDR_W:0]   sample_count;
  logic              busy, done, aborted, axi_err;
  logic [DIN_W-1:0]  fir_sample;
  logic              fir_sample_valid;
  logic [DOUT_W-1:0] fir_result;
  logic              fir_result_valid;
  fsm_state_t        state_dbg;

  fir_mem_ctrl #(.ADDR_W(ADDR_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W)) dut (
    .a_clk            (a_clk),
    .a_rst            (a_rst),
    .axi              (bus),
    .start            (start),
    .abort            (abort),
    .mode             (mode),
    .sample_count     (sample_count),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .axi_err          (axi_err),
    .err_clr          (err_clr),
    .fir_sample       (fir_sample),
    .fir_sample_valid (fir_sample_valid),
    .fir_result       (fir_result),
    .fir_result_valid (fir_result_valid),
    .state            (state_dbg)
  );

  // Reference model: input RAM image and expected sample stream.
  logic [DIN_W-1:0] model_in [DEPTH];
  logic [DIN_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int valid_cnt, done_cnt, abort_cnt, run_len, max_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DOUT_W-1:0] exp_out(input int i);
    return DOUT_W'(model_in[i]) + DOUT_W'(1);
  endfunction

  // Echo FIR: result = sample + 1, three cycles after the sample is presented.
  logic             pv [3] = '{default: 1'b0};
  logic [DIN_W-1:0] pd [3] = '{default: '0};
  always @(posedge a_clk) begin
    #1;
    if (a_rst) begin
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      fir_result_valid = 1'b0;
      fir_result = '0;
    end else begin
      fir_result_valid = pv[2];
      fir_result = DOUT_W'(pd[2]) + DOUT_W'(1);
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = fir_sample_valid; pd[0] = fir_sample;
      if (fir_sample_valid) begin
        if (exp_q.size() == 0) check("sample_unexpected", 32'd1, 32'd0);
        else check("fir_sample", 32'(fir_sample), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge a_clk) begin
    if (fir_sample_valid) begin
      valid_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge a_clk);
  endtask

  task automatic clr_counts();
    valid_cnt = 0; done_cnt = 0; abort_cnt = 0; run_len = 0; max_run = 0;
  endtask

  task automatic axi_write(input int addr, input logic [DIN_W-1:0] data);
    bus.axi_wr_addr = ADDR_W'(addr);
    bus.axi_wr_data = data;
    bus.axi_wr = 1'b1;
    cyc();
    bus.axi_wr = 1'b0;
  endtask

  task automatic model_write(input int addr, input logic [DIN_W-1:0] data);
    model_in[addr] = data;
    axi_write(addr, data);
  endtask

  task automatic axi_read(input int addr, output logic [DOUT_W-1:0] data);
    bus.axi_rd_addr = ADDR_W'(addr);
    cyc();
    data = bus.axi_rd_data;
  endtask

  task automatic check_out(input string tag, input int addr, input logic [DOUT_W-1:0] exp);
    logic [DOUT_W-1:0] d;
    axi_read(addr, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic load_exp(input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) exp_q.push_back(model_in[i]);
  endtask

  task automatic start_pass(input int n, input logic m);
    sample_count = (ADDR_W+1)'(n);
    mode = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      cyc();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_sample_valid"}, 32'(fir_sample_valid), 32'd0);
    check({tag, "_sample"}, 32'(fir_sample), 32'd0);
    check({tag, "_rd_data"}, 32'(bus.axi_rd_data), 32'd0);
    check({tag, "_axi_err"}, 32'(axi_err), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, d;
    logic [DOUT_W-1:0] rd;
    a_rst = 1'b1;
    start = 1'b0; abort = 1'b0; mode = 1'b0; err_clr = 1'b0; sample_count = '0;
    bus.axi_wr_addr = '0; bus.axi_wr_data = '0; bus.axi_wr = 1'b0; bus.axi_rd_addr = '0;
    clr_counts();
    cyc(2);
    check_quiet_outputs("reset");
    a_rst = 1'b0;
    cyc();

    // Basic pass: samples 1..8 produce results 2..9.
    for (int i = 0; i < 8; i++) model_write(i, DIN_W'(i + 1));
    load_exp(8, 1);
    clr_counts();
    start_pass(8, 1'b0);
    check("basic_busy", 32'(busy), 32'd1);
    wait_idle(100, "basic_timeout");
    check("basic_valid_cnt", 32'(valid_cnt), 32'd8);
    check("basic_consecutive", 32'(max_run), 32'd8);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_exp_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) check_out("basic_out", i, DOUT_W'(i + 2));

    // Host writes during a run are dropped and flagged; reads return zero.
    for (int i = 0; i < 8; i++) model_write(i, DIN_W'($urandom));
    load_exp(8, 1);
    clr_counts();
    start_pass(8, 1'b0);
    bus.axi_wr_addr = ADDR_W'(3);
    bus.axi_wr_data = ~model_in[3];
    bus.axi_wr = 1'b1;
    cyc();
    bus.axi_wr = 1'b0;
    check("err_set", 32'(axi_err), 32'd1);
    axi_read(5, rd);
    check("rd_during_run", 32'(rd), 32'd0);
    bus.axi_wr = 1'b1;
    err_clr = 1'b1;
    cyc();
    bus.axi_wr = 1'b0;
    err_clr = 1'b0;
    check("err_set_wins", 32'(axi_err), 32'd1);
    wait_idle(100, "err_timeout");
    check("err_sticky", 32'(axi_err), 32'd1);
    for (int i = 0; i < 8; i++) check_out("err_out", i, exp_out(i));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("err_cleared", 32'(axi_err), 32'd0);

    // Abort at the 4th sample.
    for (int i = 0; i < 8; i++) model_write(i, DIN_W'($urandom));
    load_exp(8, 1);
    clr_counts();
    start_pass(8, 1'b0);
    n = 0; k = 0;
    while (n < 4 && k < 50) begin
      cyc();
      k++;
      if (fir_sample_valid) n++;
    end
    check("abort_reach_4th", 32'(n), 32'd4);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_pulse", 32'(aborted), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    cyc();
    check("abort_pulse_end", 32'(aborted), 32'd0);
    cyc(8);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_cnt", 32'(abort_cnt), 32'd1);
    check("abort_valid_cnt", 32'(valid_cnt), 32'd4);
    exp_q.delete();

    // Abort with simultaneous start while idle: nothing starts.
    sample_count = (ADDR_W+1)'(2);
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_idle_nopulse", 32'(aborted), 32'd0);

    // Normal 2-sample pass after an abort.
    for (int i = 0; i < 2; i++) model_write(i, DIN_W'($urandom));
    load_exp(2, 1);
    clr_counts();
    start_pass(2, 1'b0);
    wait_idle(100, "post_abort_timeout");
    check("post_abort_done", 32'(done_cnt), 32'd1);
    check("post_abort_valid", 32'(valid_cnt), 32'd2);
    for (int i = 0; i < 2; i++) check_out("post_abort_out", i, exp_out(i));

    // Continuous mode: repeated passes over 4 samples until aborted.
    for (int i = 0; i < 4; i++) model_write(i, DIN_W'($urandom));
    load_exp(4, 6);
    clr_counts();
    start_pass(4, 1'b1);
    d = 0; k = 0;
    while (d < 3 && k < 200) begin
      cyc();
      k++;
      if (done) d++;
    end
    check("cont_three_passes", 32'(d), 32'd3);
    cyc();
    check("cont_still_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    mode = 1'b0;
    check("cont_abort_pulse", 32'(aborted), 32'd1);
    check("cont_abort_busy", 32'(busy), 32'd0);
    cyc(8);
    check("cont_done_cnt", 32'(done_cnt), 32'd3);
    check("cont_valid_min", 32'(valid_cnt >= 12), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) check_out("cont_out", i, exp_out(i));

    // Zero-length request is ignored.
    clr_counts();
    start_pass(0, 1'b0);
    check("zero_busy", 32'(busy), 32'd0);
    cyc(3);
    check("zero_busy_later", 32'(busy), 32'd0);
    check("zero_no_done", 32'(done_cnt), 32'd0);

    // Oversized request clamps to the full RAM depth.
    for (int i = 0; i < DEPTH; i++) model_write(i, DIN_W'($urandom));
    load_exp(DEPTH, 1);
    clr_counts();
    start_pass(DEPTH + 5, 1'b0);
    wait_idle(DEPTH + 100, "full_timeout");
    check("full_valid_cnt", 32'(valid_cnt), 32'(DEPTH));
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_exp_left", 32'(exp_q.size()), 32'd0);
    check_out("full_out_first", 0, exp_out(0));
    check_out("full_out_last", DEPTH - 1, exp_out(DEPTH - 1));
    k = $urandom_range(1, DEPTH - 2);
    check_out("full_out_rand", k, exp_out(k));

    // Reset mid-run: outputs clear at once, input RAM contents survive.
    for (int i = 0; i < 4; i++) model_write(i, model_in[i] + DIN_W'(7));
    load_exp(16, 1);
    clr_counts();
    start_pass(16, 1'b0);
    bus.axi_wr = 1'b1;
    cyc();
    bus.axi_wr = 1'b0;
    check("rst_err_before", 32'(axi_err), 32'd1);
    cyc(3);
    a_rst = 1'b1;
    #1;
    check_quiet_outputs("midrun_rst");
    cyc();
    a_rst = 1'b0;
    cyc(6);
    exp_q.delete();
    check("rst_idle", 32'(busy), 32'd0);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_no_abort", 32'(abort_cnt), 32'd0);
    load_exp(4, 1);
    clr_counts();
    start_pass(4, 1'b0);
    wait_idle(100, "rst_rerun_timeout");
    check("rst_rerun_done", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 4; i++) check_out("rst_rerun_out", i, exp_out(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mem_ctrl.md
FIR_MEM_CTRL -- requirements
Module: fir_mem_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 13, RAM address width (depth 2^ADDR_W per RAM); DIN_W, default 16, input-sample width; DOUT_W, default 16, result width (legal up to 32).
REQ-002 SHALL have ports: a_clk  in  1  sole clock, all logic on rising edge; a_rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have AXI-side ports: axi_wr_addr  in  ADDR_W  input-RAM write address; axi_wr_data  in  DIN_W  write data; axi_wr  in  1  write strobe; axi_rd_addr  in  ADDR_W  output-RAM read address; axi_rd_data  out  DOUT_W  output-RAM read data.
REQ-004 SHALL have control ports: start  in  1  run request pulse; abort  in  1  stop request; mode  in  1  0=single pass, 1=continuous; sample_count  in  ADDR_W+1  samples per pass; busy  out  1; done  out  1  end-of-pass pulse; aborted  out  1  pulse; axi_err  out  1  sticky access-during-run flag; err_clr  in  1  clears axi_err.
REQ-005 SHALL have FIR-side ports: fir_sample  out  DIN_W; fir_sample_valid  out  1; fir_result  in  DOUT_W; fir_result_valid  in  1.

Function
REQ-006 SHALL instantiate an input RAM (DIN_W x 2^ADDR_W) and an output RAM (DOUT_W x 2^ADDR_W), both with synchronous write and 1-cycle registered read.
REQ-007 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start with eff_count!=0; RUN->DONE when result count reaches eff_count; DONE->IDLE after one cycle (mode=0) or DONE->RUN (mode=1).
REQ-008 eff_count SHALL be sample_count clamped to 2^ADDR_W, latched on the IDLE->RUN transition; start with eff_count=0 SHALL be ignored.
REQ-009 In IDLE, input-RAM address/write SHALL come from axi_wr_addr/axi_wr; output-RAM address from axi_rd_addr; axi_rd_data valid one cycle after axi_rd_addr.
REQ-010 In RUN, read pointer SHALL issue addresses 0..eff_count-1, one per cycle; fir_sample_valid SHALL assert exactly one cycle after each address, with fir_sample = RAM data.
REQ-011 In RUN, each fir_result_valid SHALL write fir_result to output RAM at write pointer (starting 0) and increment it; results arriving after eff_count SHALL be discarded.
REQ-012 In RUN, axi_wr SHALL be dropped (no RAM write) and set axi_err; axi_rd_data SHALL read 0.
REQ-013 axi_err SHALL set on any REQ-012 event, clear on err_clr; set wins on the same cycle.
REQ-014 busy SHALL be 1 in RUN and DONE, 0 in IDLE; done SHALL pulse exactly one cycle while in DONE.
REQ-015 abort in RUN or DONE SHALL force IDLE next cycle, reset both pointers, pulse aborted for one cycle, suppress done; abort in IDLE SHALL have no effect; abort wins over simultaneous start.
REQ-016 start while busy SHALL be ignored; in mode=1 each new pass SHALL restart pointers at 0 with the latched eff_count.
REQ-017 Pointers SHALL be ADDR_W+1 bits so count 2^ADDR_W terminates without wrap.

Reset
REQ-018 On a_rst SHALL enter IDLE, clear pointers, eff_count, axi_err; busy, done, aborted, fir_sample_valid SHALL be 0 and fir_sample, axi_rd_data 0 (registered read path cleared).
REQ-019 Reset mid-RUN SHALL abandon the pass without done/aborted pulse; RAM contents SHALL be unaffected.

Structure
REQ-020 Package fir_mem_pkg SHALL hold the FSM state enum and default ADDR_W/DIN_W/DOUT_W constants.
REQ-021 The existing ram module SHALL be the sub-module, instantiated twice; address muxing, pointers and FSM stay in fir_mem_ctrl.

Verification
REQ-022 Write 8 samples 1..8 via AXI, sample_count=8, start, FIR model echoes sample+1 with 3-cycle latency -> fir_sample_valid 8 consecutive cycles, done one pulse, output RAM reads 2..9.
REQ-023 axi_wr during RUN -> RAM unchanged, axi_err=1 until err_clr; axi_rd_data=0 during RUN.
REQ-024 abort at 4th sample -> aborted pulse, busy=0 next cycle, no done; new start with sample_count=2 completes normally.
REQ-025 mode=1, sample_count=4 -> done pulses every pass, pointers restart at 0, stops only on abort.
REQ-026 sample_count=0 start -> stays IDLE; sample_count=2^ADDR_W+5 -> exactly 2^ADDR_W samples processed.
REQ-027 a_rst asserted mid-RUN -> all outputs 0 immediately, IDLE, previously written input RAM data still readable by next run.
